row_buffer_ctrl: RTL and testbench

Sequencing controller for the row-buffer memory module (`MM`). It accepts a raster pixel stream and generates `MM` write/read strobes and addresses. For each accepted pixel it delivers one vertical window column downstream: the `RB_COUNT` buffered rows, ordered oldest-first, plus the live pixel. It sits between the pixel source and the convolution/window datapath and owns the row-slot rotation and frame fill/run sequencing.

---
 rtl/rb_pkg.sv | 22 ++
 rtl/rb_lane_rotate.sv | 25 ++
 rtl/row_buffer_ctrl.sv | 156 +++++++++++++++
 tb/tb_row_buffer_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared state encoding and index helpers for the row-buffer sequencing controller.
package rb_pkg;

  localparam int RB_STATE_W = 2;

  typedef enum logic [RB_STATE_W-1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } rb_state_e;

  // Counter/index width that stays legal (>=1 bit) for a single-entry range.
  function automatic int rb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rb_lane_mod(input int a, input int n);
    return a % n;
  endfunction

endpackage

// File: rtl/rb_lane_rotate.sv
// Reorders MM lanes into oldest-first window order starting at the head lane;
// masked slices are forced to zero.
module rb_lane_rotate
  import rb_pkg::*;
#(
  parameter int PIXEL_BITS = 8,
  parameter int RB_COUNT   = 8,
  parameter int HEAD_W     = 3
) (
  input  logic [PIXEL_BITS*RB_COUNT-1:0] lanes,
  input  logic [HEAD_W-1:0]              head,
  input  logic [RB_COUNT-1:0]            mask,
  output logic [PIXEL_BITS*RB_COUNT-1:0] ordered
);

  always_comb begin
    ordered = '0;
    for (int k = 0; k < RB_COUNT; k++) begin
      if (!mask[k])
        ordered[k*PIXEL_BITS +: PIXEL_BITS] =
          lanes[rb_lane_mod(int'(head) + k, RB_COUNT)*PIXEL_BITS +: PIXEL_BITS];
    end
  end

endmodule

// File: rtl/row_buffer_ctrl.sv
// Row-buffer sequencing controller: MM strobes/addresses, row-slot rotation, window column output.
// Optional build macro RB_CTRL_FILL_OUT_EN: emit zero-padded columns during FILL as well.
module row_buffer_ctrl
  import rb_pkg::*;
#(
  parameter int PIXEL_BITS   = 8,
  parameter int IMAGE_WIDTH  = 256,
  parameter int IMAGE_HEIGHT = 256,
  parameter int KERNEL_SIZE  = 9,
  parameter int RB_COUNT     = KERNEL_SIZE - 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [PIXEL_BITS-1:0]                   s_data,
  output logic                                    mem_we,
  output logic [$clog2(RB_COUNT*IMAGE_WIDTH)-1:0] mem_write_addr,
  output logic [PIXEL_BITS-1:0]                   mem_write_data,
  output logic                                    mem_re,
  output logic [$clog2(IMAGE_WIDTH)-1:0]          mem_read_addr,
  input  logic [PIXEL_BITS*RB_COUNT-1:0]          mem_read_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [PIXEL_BITS*(RB_COUNT+1)-1:0]      m_column,
  output logic [$clog2(IMAGE_WIDTH)-1:0]          m_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]         m_row,
  output logic                                    frame_done
);

  localparam int WA_W = $clog2(RB_COUNT*IMAGE_WIDTH);
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int RW   = $clog2(IMAGE_HEIGHT);
  localparam int HW   = rb_width(RB_COUNT);

  rb_state_e       state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [HW-1:0]   head;
  logic [HW-1:0]   head_nxt;
  logic            accept, emit, col_last, row_last;

  logic                         vld_p1;
  logic [PIXEL_BITS-1:0]        data_p1;
  logic [HW-1:0]                head_p1;
  logic [CW-1:0]                col_p1;
  logic [RW-1:0]                row_p1;
  logic [RB_COUNT-1:0]          mask_p1;
  logic [PIXEL_BITS*RB_COUNT-1:0] lanes_p1;

  // Stage 0: accept handshake, MM strobes and addresses
  assign s_ready  = rst & (state != DONE) & (~vld_p1 | m_ready);
  assign accept   = s_valid & s_ready;
  assign col_last = (col == CW'(IMAGE_WIDTH-1));
  assign row_last = (row == RW'(IMAGE_HEIGHT-1));
  assign head_nxt = (head == HW'(RB_COUNT-1)) ? '0 : head + 1'b1;

`ifdef RB_CTRL_FILL_OUT_EN
  assign emit = accept;
`else
  assign emit = accept & (state == RUN);
`endif

  assign mem_we         = accept;
  assign mem_re         = accept;
  assign mem_read_addr  = col;
  assign mem_write_addr = WA_W'(col) * WA_W'(RB_COUNT) + WA_W'(head);
  assign mem_write_data = s_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      head       <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      head       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col  <= '0;
          row  <= row_last ? '0 : row + 1'b1;
          head <= head_nxt;
        end else begin
          col <= col + 1'b1;
        end
      end
      unique case (state)
        IDLE: if (accept) state <= FILL;
        FILL: if (accept && col_last && row == RW'(RB_COUNT-1)) state <= RUN;
        RUN: begin
          if (accept && col_last && row_last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Stage 1: output register, aligned with the 1-cycle MM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      head_p1 <= '0;
      col_p1  <= '0;
      row_p1  <= '0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
    end else begin
      if (emit)         vld_p1 <= 1'b1;
      else if (m_ready) vld_p1 <= 1'b0;
      if (accept) begin
        data_p1 <= s_data;
        head_p1 <= head;
        col_p1  <= col;
        row_p1  <= row;
      end
    end
  end

  // Lanes not yet written this frame are the top border: slice k < RB_COUNT - row.
  always_comb begin
    mask_p1 = '0;
`ifdef RB_CTRL_FILL_OUT_EN
    for (int k = 0; k < RB_COUNT; k++)
      if (int'(row_p1) + k < RB_COUNT) mask_p1[k] = 1'b1;
`endif
  end

  rb_lane_rotate #(
    .PIXEL_BITS(PIXEL_BITS),
    .RB_COUNT  (RB_COUNT),
    .HEAD_W    (HW)
  ) u_rotate (
    .lanes  (mem_read_data),
    .head   (head_p1),
    .mask   (mask_p1),
    .ordered(lanes_p1)
  );

  assign m_valid  = vld_p1;
  assign m_column = vld_p1 ? {data_p1, lanes_p1} : '0;
  assign m_col    = col_p1;
  assign m_row    = row_p1;

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Scoreboard bench for row_buffer_ctrl on a 4x5 image with two buffered rows.
module tb_row_buffer_ctrl;

  localparam int P   = 8;
  localparam int W   = 4;
  localparam int H   = 5;
  localparam int K   = 3;
  localparam int RB  = 2;
  localparam int WA_W = $clog2(RB*W);
  localparam int CW  = $clog2(W);
  localparam int RW  = $clog2(H);
  localparam int CLW = P*(RB+1);
`ifdef RB_CTRL_FILL_OUT_EN
  localparam int EXP_BEATS = W*H;
`else
  localparam int EXP_BEATS = W*(H-RB);
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clear = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [P-1:0]    s_data = '0;
  logic            mem_we, mem_re;
  logic [WA_W-1:0] mem_write_addr;
  logic [P-1:0]    mem_write_data;
  logic [CW-1:0]   mem_read_addr;
  logic [P*RB-1:0] mem_read_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [CLW-1:0]  m_column;
  logic [CW-1:0]   m_col;
  logic [RW-1:0]   m_row;
  logic            frame_done;

  row_buffer_ctrl #(
    .PIXEL_BITS(P), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_SIZE(K), .RB_COUNT(RB)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_re(mem_re), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_column(m_column),
    .m_col(m_col), .m_row(m_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Row-buffer memory: read-before-write, one-cycle read; poisoned while in reset.
  logic [P-1:0] mm [RB][W];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RB; i++)
        for (int j = 0; j < W; j++) mm[i][j] <= 8'hEE;
    end else begin
      if (mem_re)
        for (int i = 0; i < RB; i++) mem_read_data[i*P +: P] <= mm[i][mem_read_addr];
      if (mem_we) mm[mem_write_addr % RB][mem_write_addr / RB] <= mem_write_data;
    end
  end

  typedef struct packed {
    logic [CLW-1:0] col;
    logic [CW-1:0]  c;
    logic [RW-1:0]  r;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int compared = 0, mismatched = 0, beats = 0, fd_cnt = 0;
  int b0, f0;
  bit head_known = 1'b0;

  function automatic logic [CLW-1:0] exp_col(input int c, input int r);
    logic [CLW-1:0] v;
    v = '0;
    for (int k = 0; k < RB; k++)
      if (r - RB + k >= 0) v[k*P +: P] = P'((r - RB + k)*16 + c);
    v[RB*P +: P] = P'(r*16 + c);
    return v;
  endfunction

  function automatic bit emits(input int r);
`ifdef RB_CTRL_FILL_OUT_EN
    return (r >= 0);
`else
    return (r >= RB);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic send(input int c, input int r);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = P'(r*16 + c);
    while (!got) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        chk("mem_we_on_accept", 32'(mem_we), 32'd1);
        chk("mem_re_on_accept", 32'(mem_re), 32'd1);
        chk("mem_read_addr", 32'(mem_read_addr), 32'(c));
        chk("mem_write_data", 32'(mem_write_data), 32'(r*16 + c));
        if (head_known && c == 3 && r == 1) chk("waddr_3_1", 32'(mem_write_addr), 32'd7);
        if (head_known && c == 1 && r == 2) chk("waddr_1_2", 32'(mem_write_addr), 32'd2);
        if (emits(r)) exp_q.push_back('{exp_col(c, r), CW'(c), RW'(r)});
      end else if (++t > 50) begin
        got = 1'b1;
        compared++;
        mismatched++;
        $display("FAIL send_timeout: pixel (%0d,%0d) never accepted, want accept", c, r);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stall_check();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h32;
    repeat (3) begin
      @(negedge clk);
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_mem_re", 32'(mem_re), 32'd0);
      chk("stall_mem_we", 32'(mem_we), 32'd0);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_column", 32'(m_column), 32'h312111);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
  endtask

  task automatic full_frame(input string tag, input bit do_stall);
    b0 = beats;
    f0 = fd_cnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(c, r);
        if (c == 0 && r == 2) begin
          s_valid = 1'b0;
          @(negedge clk);
          chk({tag, "_first_run_column"}, 32'(m_column), 32'h201000);
          @(posedge clk);
          #1;
        end
        if (do_stall && c == 1 && r == 3) stall_check();
      end
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_beats"}, 32'(beats - b0), 32'(EXP_BEATS));
    chk({tag, "_frame_done_pulses"}, 32'(fd_cnt - f0), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst && frame_done) fd_cnt++;
    if (rst && m_valid && m_ready) begin
      beats++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL beat_unexpected: got column %0h at (%0d,%0d), want no beat",
                 m_column, m_col, m_row);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_column, m_col, m_row} !== {mon_e.col, mon_e.c, mon_e.r}) begin
          mismatched++;
          $display("FAIL beat_data: got %0h at (%0d,%0d), want %0h at (%0d,%0d)",
                   m_column, m_col, m_row, mon_e.col, mon_e.c, mon_e.r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_column", 32'(m_column), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    chk("idle_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    head_known = 1'b1;
    full_frame("frame1", 1'b1);
    head_known = 1'b0;

    // Aborted frame: clear right after pixel (1,3)
    for (int i = 0; i < W*3 + 2; i++) send(i % W, i / W);
    s_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_m_valid", 32'(m_valid), 32'd0);
    chk("clear_s_ready", 32'(s_ready), 32'd1);
    chk("clear_col", 32'(mem_read_addr), 32'd0);
    chk("clear_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    head_known = 1'b1;
    full_frame("frame3", 1'b0);
    head_known = 1'b0;

    // Reset asserted between edges while a RUN beat is held
    for (int i = 0; i < W*2 + 2; i++) send(i % W, i / W);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_s_ready", 32'(s_ready), 32'd0);
    chk("async_mem_we", 32'(mem_we), 32'd0);
    chk("async_mem_re", 32'(mem_re), 32'd0);
    chk("async_waddr", 32'(mem_write_addr), 32'd0);
    chk("async_raddr", 32'(mem_read_addr), 32'd0);
    chk("async_m_valid", 32'(m_valid), 32'd0);
    chk("async_m_column", 32'(m_column), 32'd0);
    chk("async_m_col", 32'(m_col), 32'd0);
    chk("async_m_row", 32'(m_row), 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b1;

    head_known = 1'b1;
    full_frame("frame5", 1'b0);
    head_known = 1'b0;

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("total_frame_done", 32'(fd_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
